// File: rtl/store_commit_unit.sv
// Store commit unit: captures store results per ROB tag, queues committed stores in order,
// and arbitrates the single D-cache port between LSB loads and committed-store writes.
module store_commit_unit #(
    parameter int unsigned NUM_LDST_RS = 3,
    parameter int unsigned ROB_DEPTH   = 6,
    parameter int unsigned TAG_W       = 3,
    parameter int unsigned DEPTH       = 4
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               flush,
    input  logic [NUM_LDST_RS-1:0]             st_valid,
    input  logic [NUM_LDST_RS-1:0][TAG_W-1:0]  st_tag,
    input  logic [NUM_LDST_RS-1:0][31:0]       st_addr,
    input  logic [NUM_LDST_RS-1:0][31:0]       st_data,
    input  logic [NUM_LDST_RS-1:0][2:0]        st_funct,
    input  logic                               commit_valid,
    input  logic [TAG_W-1:0]                   commit_tag,
    input  logic                               commit_is_store,
    output logic                               commit_full,
    output logic                               commit_err,
    input  logic                               ld_read,
    input  logic [31:0]                        ld_addr,
    output logic                               ld_resp,
    output logic [31:0]                        ld_rdata,
    output logic                               mem_read_d,
    output logic                               mem_write_d,
    output logic [3:0]                         mem_byte_enable_d,
    output logic [31:0]                        mem_address_d,
    output logic [31:0]                        mem_wdata_d,
    input  logic                               mem_resp_d,
    input  logic [31:0]                        mem_rdata_d,
    output logic                               new_store,
    output logic [$clog2(DEPTH):0]             fifo_count
);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;
    localparam int unsigned TBL_N = 2 ** TAG_W;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
        logic [2:0]  funct;
    } store_t;

    typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_STORE} state_t;

    state_t             r_state, w_next;
    store_t             r_tbl [TBL_N];
    logic [TBL_N-1:0]   r_tbl_valid;
    store_t             r_fifo [DEPTH];
    logic [PTR_W-1:0]   r_wptr, r_rptr;
    logic [CNT_W-1:0]   r_count;
    logic [31:0]        r_ld_addr;
    logic               r_ld_flushed;
    logic               r_commit_err;
    logic               r_new_store;

    logic               w_byp_hit;
    store_t             w_byp_ent;
    logic               w_commit_st;
    logic               w_push;
    logic               w_pop;
    store_t             w_push_ent;
    store_t             w_head;
    logic [3:0]         w_be;
    logic [31:0]        w_wdata;

    // Same-cycle capture of the committing tag overrides the table entry
    always_comb begin
        w_byp_hit = 1'b0;
        w_byp_ent = '0;
        for (int unsigned i = 0; i < NUM_LDST_RS; i++) begin
            if (st_valid[i] && (st_tag[i] == commit_tag) && (commit_tag != '0)) begin
                w_byp_hit = 1'b1;
                w_byp_ent = {st_addr[i], st_data[i], st_funct[i]};
            end
        end
    end

    assign commit_full = (r_count == CNT_W'(DEPTH));
    assign w_commit_st = commit_valid && commit_is_store && !commit_full;
    assign w_push      = w_commit_st && (w_byp_hit || r_tbl_valid[commit_tag]);
    assign w_push_ent  = w_byp_hit ? w_byp_ent : r_tbl[commit_tag];
    assign w_pop       = (r_state == ST_STORE) && mem_resp_d;
    assign w_head      = r_fifo[r_rptr];
    assign fifo_count  = r_count;
    assign commit_err  = r_commit_err;
    assign new_store   = r_new_store;

    // Speculative per-tag store table; flush drops everything including same-cycle captures
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_tbl_valid <= '0;
            for (int unsigned i = 0; i < TBL_N; i++) r_tbl[i] <= '0;
        end else if (flush) begin
            r_tbl_valid <= '0;
        end else begin
            for (int unsigned i = 0; i < NUM_LDST_RS; i++) begin
                if (st_valid[i] && (st_tag[i] != '0) && (st_tag[i] <= TAG_W'(ROB_DEPTH))) begin
                    r_tbl_valid[st_tag[i]] <= 1'b1;
                    r_tbl[st_tag[i]]       <= {st_addr[i], st_data[i], st_funct[i]};
                end
            end
            if (w_commit_st) r_tbl_valid[commit_tag] <= 1'b0;
        end
    end

    // In-order committed-store FIFO
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) r_fifo[i] <= '0;
        end else begin
            if (w_push) begin
                r_fifo[r_wptr] <= w_push_ent;
                r_wptr         <= r_wptr + PTR_W'(1);
            end
            if (w_pop) r_rptr <= r_rptr + PTR_W'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state      <= ST_IDLE;
            r_ld_addr    <= '0;
            r_ld_flushed <= 1'b0;
            r_commit_err <= 1'b0;
            r_new_store  <= 1'b0;
        end else begin
            r_state     <= w_next;
            r_new_store <= w_pop;
            if (w_commit_st && !w_push) r_commit_err <= 1'b1;
            if ((r_state == ST_IDLE) && (w_next == ST_LOAD)) begin
                r_ld_addr    <= ld_addr;
                r_ld_flushed <= 1'b0;
            end else if ((r_state == ST_LOAD) && flush) begin
                r_ld_flushed <= 1'b1;
            end
        end
    end

    // Byte-lane formatting of the FIFO head
    always_comb begin
        w_be    = 4'b1111;
        w_wdata = w_head.data;
        case (w_head.funct)
            3'b000: begin
                w_be    = 4'b0001 << w_head.addr[1:0];
                w_wdata = {4{w_head.data[7:0]}};
            end
            3'b001: begin
                w_be    = 4'b0011 << {w_head.addr[1], 1'b0};
                w_wdata = {2{w_head.data[15:0]}};
            end
            default: ;
        endcase
    end

    // Arbiter next-state and port outputs
    always_comb begin
        w_next            = r_state;
        mem_read_d        = 1'b0;
        mem_write_d       = 1'b0;
        mem_address_d     = '0;
        mem_byte_enable_d = '0;
        mem_wdata_d       = '0;
        ld_resp           = 1'b0;
        ld_rdata          = '0;
        case (r_state)
            ST_IDLE: begin
                if ((r_count != '0) && (commit_full || !ld_read)) w_next = ST_STORE;
                else if (ld_read)                                  w_next = ST_LOAD;
            end
            ST_LOAD: begin
                mem_read_d    = 1'b1;
                mem_address_d = r_ld_addr;
                if (mem_resp_d) begin
                    w_next = ST_IDLE;
                    if (!r_ld_flushed && !flush) begin
                        ld_resp  = 1'b1;
                        ld_rdata = mem_rdata_d;
                    end
                end
            end
            ST_STORE: begin
                mem_write_d       = 1'b1;
                mem_address_d     = {w_head.addr[31:2], 2'b00};
                mem_byte_enable_d = w_be;
                mem_wdata_d       = w_wdata;
                if (mem_resp_d) w_next = ST_IDLE;
            end
            default: w_next = ST_IDLE;
        endcase
    end

endmodule

// File: tb/tb_store_commit_unit.sv
// Self-checking bench for store_commit_unit: a tag-table/queue reference model tracks
// captures, commits and retirements, and each scenario task checks the DUT against it.
module tb_store_commit_unit;
    localparam int NL = 3;
    localparam int RD = 6;
    localparam int TW = 3;
    localparam int DP = 4;

    logic                    clk = 1'b0;
    logic                    rst;
    logic                    flush;
    logic [NL-1:0]           st_valid;
    logic [NL-1:0][TW-1:0]   st_tag;
    logic [NL-1:0][31:0]     st_addr;
    logic [NL-1:0][31:0]     st_data;
    logic [NL-1:0][2:0]      st_funct;
    logic                    commit_valid;
    logic [TW-1:0]           commit_tag;
    logic                    commit_is_store;
    logic                    commit_full;
    logic                    commit_err;
    logic                    ld_read;
    logic [31:0]             ld_addr;
    logic                    ld_resp;
    logic [31:0]             ld_rdata;
    logic                    mem_read_d;
    logic                    mem_write_d;
    logic [3:0]              mem_byte_enable_d;
    logic [31:0]             mem_address_d;
    logic [31:0]             mem_wdata_d;
    logic                    mem_resp_d;
    logic [31:0]             mem_rdata_d;
    logic                    new_store;
    logic [2:0]              fifo_count;

    store_commit_unit #(.NUM_LDST_RS(NL), .ROB_DEPTH(RD), .TAG_W(TW), .DEPTH(DP)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .st_valid(st_valid), .st_tag(st_tag), .st_addr(st_addr), .st_data(st_data), .st_funct(st_funct),
        .commit_valid(commit_valid), .commit_tag(commit_tag), .commit_is_store(commit_is_store),
        .commit_full(commit_full), .commit_err(commit_err),
        .ld_read(ld_read), .ld_addr(ld_addr), .ld_resp(ld_resp), .ld_rdata(ld_rdata),
        .mem_read_d(mem_read_d), .mem_write_d(mem_write_d), .mem_byte_enable_d(mem_byte_enable_d),
        .mem_address_d(mem_address_d), .mem_wdata_d(mem_wdata_d),
        .mem_resp_d(mem_resp_d), .mem_rdata_d(mem_rdata_d),
        .new_store(new_store), .fifo_count(fifo_count)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
        logic [2:0]  funct;
    } ent_t;

    // Reference model state
    bit   m_valid [8];
    ent_t m_tbl   [8];
    ent_t q[$];
    bit   m_err;
    bit   m_new_store;

    int checks = 0;
    int errors = 0;

    function automatic logic [3:0] fmt_be(input ent_t e);
        case (e.funct)
            3'b000:  return (e.addr[1:0] == 2'd0) ? 4'b0001 : (e.addr[1:0] == 2'd1) ? 4'b0010 :
                            (e.addr[1:0] == 2'd2) ? 4'b0100 : 4'b1000;
            3'b001:  return e.addr[1] ? 4'b1100 : 4'b0011;
            default: return 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] fmt_wd(input ent_t e);
        case (e.funct)
            3'b000:  return {e.data[7:0], e.data[7:0], e.data[7:0], e.data[7:0]};
            3'b001:  return {e.data[15:0], e.data[15:0]};
            default: return e.data;
        endcase
    endfunction

    function automatic ent_t rand_ent();
        ent_t e;
        e.data  = $urandom;
        e.addr  = $urandom;
        e.funct = 3'($urandom_range(0, 2));
        if (e.funct == 3'b001) e.addr[0] = 1'b0;
        if (e.funct == 3'b010) e.addr[1:0] = 2'b00;
        return e;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 8; i++) m_valid[i] = 1'b0;
        q.delete();
        m_err       = 1'b0;
        m_new_store = 1'b0;
    endtask

    task automatic clear_pulses();
        st_valid        = '0;
        commit_valid    = 1'b0;
        commit_is_store = 1'b0;
        flush           = 1'b0;
        mem_resp_d      = 1'b0;
    endtask

    // Advance one clock, applying this cycle's inputs to the reference model first
    task automatic step();
        bit   popped;
        ent_t e;
        popped = mem_write_d && mem_resp_d;
        if (!flush) begin
            for (int i = 0; i < NL; i++) begin
                if (st_valid[i] && st_tag[i] != 0 && int'(st_tag[i]) <= RD) begin
                    m_valid[st_tag[i]] = 1'b1;
                    m_tbl[st_tag[i]]   = {st_addr[i], st_data[i], st_funct[i]};
                end
            end
        end
        if (commit_valid && commit_is_store && q.size() < DP) begin
            if (m_valid[commit_tag]) begin
                q.push_back(m_tbl[commit_tag]);
                m_valid[commit_tag] = 1'b0;
            end else begin
                m_err = 1'b1;
            end
        end
        if (popped) e = q.pop_front();
        if (flush) for (int i = 0; i < 8; i++) m_valid[i] = 1'b0;
        m_new_store = popped;
        @(posedge clk);
        #1;
        clear_pulses();
    endtask

    task automatic capture(input int lane, input int tag, input ent_t e);
        st_valid[lane] = 1'b1;
        st_tag[lane]   = TW'(tag);
        st_addr[lane]  = e.addr;
        st_data[lane]  = e.data;
        st_funct[lane] = e.funct;
    endtask

    task automatic commit(input int tag);
        commit_valid    = 1'b1;
        commit_is_store = 1'b1;
        commit_tag      = TW'(tag);
    endtask

    task automatic wait_write(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (mem_write_d) begin
                ok = 1'b1;
                break;
            end
            step();
        end
    endtask

    // Waits for a write, records what the port shows, then answers it after a random delay
    task automatic serve_write(output bit ok, output logic [31:0] a, output logic [3:0] be,
                               output logic [31:0] wd, output ent_t e);
        wait_write(ok);
        a = mem_address_d; be = mem_byte_enable_d; wd = mem_wdata_d;
        e = (q.size() > 0) ? q[0] : '0;
        if (!ok) return;
        repeat ($urandom_range(0, 2)) step();
        mem_resp_d = 1'b1;
        step();
    endtask

    task automatic test_reset();
        rst = 1'b0;
        clear_pulses();
        st_tag = '0; st_addr = '0; st_data = '0; st_funct = '0;
        commit_tag = '0; ld_read = 1'b0; ld_addr = '0; mem_rdata_d = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        checks++; if (mem_read_d !== 1'b0) begin errors++; $display("FAIL reset_mem_read: got %b expected 0", mem_read_d); end
        checks++; if (mem_write_d !== 1'b0) begin errors++; $display("FAIL reset_mem_write: got %b expected 0", mem_write_d); end
        checks++; if (fifo_count !== 3'd0) begin errors++; $display("FAIL reset_count: got %0d expected 0", fifo_count); end
        checks++; if (commit_full !== 1'b0) begin errors++; $display("FAIL reset_full: got %b expected 0", commit_full); end
        checks++; if (commit_err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b expected 0", commit_err); end
        checks++; if (new_store !== 1'b0) begin errors++; $display("FAIL reset_new_store: got %b expected 0", new_store); end
        checks++; if (ld_resp !== 1'b0) begin errors++; $display("FAIL reset_ld_resp: got %b expected 0", ld_resp); end
        checks++; if (mem_address_d !== 32'd0 || mem_byte_enable_d !== 4'd0 || mem_wdata_d !== 32'd0)
            begin errors++; $display("FAIL reset_mem_bus: got %h/%h/%h expected 0", mem_address_d, mem_byte_enable_d, mem_wdata_d); end
        rst = 1'b1;
        step();
    endtask

    task automatic test_sw_basic();
        bit ok; logic [31:0] a, wd; logic [3:0] be; ent_t e, s;
        s = {32'h0000_0104, 32'hAABB_CCDD, 3'b010};
        capture(1, 3, s);
        step();
        commit(3);
        step();
        checks++; if (fifo_count !== 3'(q.size())) begin errors++; $display("FAIL sw_count: got %0d expected %0d", fifo_count, q.size()); end
        serve_write(ok, a, be, wd, e);
        checks++; if (!ok) begin errors++; $display("FAIL sw_timeout: got no write expected write"); end
        checks++; if (a !== 32'h104 || be !== 4'b1111 || wd !== 32'hAABBCCDD)
            begin errors++; $display("FAIL sw_write: got %h/%b/%h expected 00000104/1111/aabbccdd", a, be, wd); end
        checks++; if (new_store !== 1'b1) begin errors++; $display("FAIL sw_new_store: got %b expected 1", new_store); end
        checks++; if (fifo_count !== 3'd0) begin errors++; $display("FAIL sw_count_after: got %0d expected 0", fifo_count); end
        step();
        checks++; if (new_store !== 1'b0) begin errors++; $display("FAIL sw_pulse_len: got %b expected 0", new_store); end
    endtask

    task automatic test_sub_word();
        bit ok; logic [31:0] a, wd; logic [3:0] be; ent_t e;
        capture(0, 1, {32'h0000_0203, 32'h0000_005A, 3'b000});
        capture(2, 2, {32'h0000_0302, 32'h0000_1234, 3'b001});
        step();
        commit(1); step();
        commit(2); step();
        serve_write(ok, a, be, wd, e);
        checks++; if (!ok || a !== 32'h200 || be !== 4'b1000 || wd !== 32'h5A5A5A5A)
            begin errors++; $display("FAIL sb_write: got %b %h/%b/%h expected 1 00000200/1000/5a5a5a5a", ok, a, be, wd); end
        serve_write(ok, a, be, wd, e);
        checks++; if (!ok || a !== 32'h300 || be !== 4'b1100 || wd !== 32'h12341234)
            begin errors++; $display("FAIL sh_write: got %b %h/%b/%h expected 1 00000300/1100/12341234", ok, a, be, wd); end
    endtask

    task automatic test_load_first();
        bit ok; logic [31:0] a, wd, rd; logic [3:0] be; ent_t e, s;
        s = rand_ent();
        capture(0, 4, s);
        step();
        commit(4); ld_read = 1'b1; ld_addr = 32'h401;
        step();
        checks++; if (mem_read_d !== 1'b1 || mem_write_d !== 1'b0 || mem_address_d !== 32'h401)
            begin errors++; $display("FAIL load_issue: got rd=%b wr=%b addr=%h expected 1 0 00000401", mem_read_d, mem_write_d, mem_address_d); end
        checks++; if (fifo_count !== 3'd1) begin errors++; $display("FAIL load_pending: got %0d expected 1", fifo_count); end
        repeat ($urandom_range(0, 2)) step();
        rd = $urandom; mem_rdata_d = rd; mem_resp_d = 1'b1;
        #1;
        checks++; if (ld_resp !== 1'b1 || ld_rdata !== rd)
            begin errors++; $display("FAIL load_resp: got %b/%h expected 1/%h", ld_resp, ld_rdata, rd); end
        step();
        ld_read = 1'b0;
        serve_write(ok, a, be, wd, e);
        checks++; if (!ok || a !== {s.addr[31:2], 2'b00} || be !== fmt_be(s) || wd !== fmt_wd(s))
            begin errors++; $display("FAIL load_then_store: got %b %h/%b/%h expected 1 %h/%b/%h", ok, a, be, wd, {s.addr[31:2], 2'b00}, fmt_be(s), fmt_wd(s)); end
        // a flush while the load is outstanding swallows its response
        ld_read = 1'b1; ld_addr = $urandom;
        step();
        flush = 1'b1;
        step();
        mem_rdata_d = $urandom; mem_resp_d = 1'b1;
        #1;
        checks++; if (ld_resp !== 1'b0 || mem_read_d !== 1'b1)
            begin errors++; $display("FAIL load_flushed: got resp=%b rd=%b expected 0 1", ld_resp, mem_read_d); end
        step();
        ld_read = 1'b0;
        #1;
        checks++; if (mem_read_d !== 1'b0) begin errors++; $display("FAIL load_flush_idle: got %b expected 0", mem_read_d); end
    endtask

    task automatic test_full();
        bit ok; logic [31:0] a, wd; logic [3:0] be; ent_t e;
        ld_read = 1'b1; ld_addr = $urandom;
        step();
        capture(0, 1, rand_ent()); capture(1, 2, rand_ent()); capture(2, 3, rand_ent());
        step();
        capture(0, 4, rand_ent()); capture(1, 5, rand_ent()); commit(1);
        step();
        for (int t = 2; t <= 4; t++) begin commit(t); step(); end
        checks++; if (fifo_count !== 3'd4 || commit_full !== 1'b1)
            begin errors++; $display("FAIL full_flag: got %0d/%b expected 4/1", fifo_count, commit_full); end
        commit(5);
        step();
        checks++; if (fifo_count !== 3'(q.size()) || commit_err !== m_err)
            begin errors++; $display("FAIL full_ignore: got %0d/%b expected %0d/%b", fifo_count, commit_err, q.size(), m_err); end
        mem_resp_d = 1'b1;
        step();
        step();
        checks++; if (mem_write_d !== 1'b1 || mem_read_d !== 1'b0)
            begin errors++; $display("FAIL full_store_wins: got wr=%b rd=%b expected 1 0", mem_write_d, mem_read_d); end
        serve_write(ok, a, be, wd, e);
        checks++; if (!ok || a !== {e.addr[31:2], 2'b00} || be !== fmt_be(e) || wd !== fmt_wd(e))
            begin errors++; $display("FAIL full_first: got %b %h/%b/%h expected 1 %h/%b/%h", ok, a, be, wd, {e.addr[31:2], 2'b00}, fmt_be(e), fmt_wd(e)); end
        commit(5);
        step();
        checks++; if (fifo_count !== 3'(q.size()) || q.size() != 4)
            begin errors++; $display("FAIL full_refill: got %0d expected 4", fifo_count); end
        mem_resp_d = 1'b1;
        step();
        ld_read = 1'b0;
        for (int k = 0; k < 4; k++) begin
            serve_write(ok, a, be, wd, e);
            checks++; if (!ok || a !== {e.addr[31:2], 2'b00} || be !== fmt_be(e) || wd !== fmt_wd(e))
                begin errors++; $display("FAIL full_drain%0d: got %b %h/%b/%h expected 1 %h/%b/%h", k, ok, a, be, wd, {e.addr[31:2], 2'b00}, fmt_be(e), fmt_wd(e)); end
        end
        checks++; if (fifo_count !== 3'd0) begin errors++; $display("FAIL full_empty: got %0d expected 0", fifo_count); end
    endtask

    task automatic test_random();
        bit   used [8];
        bit   ok; logic [31:0] a, wd; logic [3:0] be; ent_t e;
        int   t;
        for (int cyc = 0; cyc < 300; cyc++) begin
            for (int i = 0; i < 8; i++) used[i] = 1'b0;
            for (int l = 0; l < NL; l++) begin
                t = $urandom_range(1, RD);
                if ($urandom_range(0, 2) == 0 && !used[t]) begin
                    used[t] = 1'b1;
                    capture(l, t, rand_ent());
                end
            end
            t = $urandom_range(1, RD);
            if ($urandom_range(0, 1) == 0 && (m_valid[t] || used[t])) commit(t);
            else if ($urandom_range(0, 19) == 0) flush = 1'b1;
            if (mem_write_d && $urandom_range(0, 2) == 0) begin
                e = q[0];
                checks++; if (mem_address_d !== {e.addr[31:2], 2'b00} || mem_byte_enable_d !== fmt_be(e) || mem_wdata_d !== fmt_wd(e))
                    begin errors++; $display("FAIL rand_write: got %h/%b/%h expected %h/%b/%h", mem_address_d, mem_byte_enable_d, mem_wdata_d, {e.addr[31:2], 2'b00}, fmt_be(e), fmt_wd(e)); end
                mem_resp_d = 1'b1;
            end
            step();
            checks++; if (fifo_count !== 3'(q.size()) || commit_full !== (q.size() == DP) || new_store !== m_new_store || commit_err !== m_err)
                begin errors++; $display("FAIL rand_state: got cnt=%0d full=%b ns=%b err=%b expected %0d %b %b %b", fifo_count, commit_full, new_store, commit_err, q.size(), q.size() == DP, m_new_store, m_err); end
        end
        for (int k = 0; k < 8 && q.size() > 0; k++) begin
            serve_write(ok, a, be, wd, e);
            checks++; if (!ok || a !== {e.addr[31:2], 2'b00} || be !== fmt_be(e) || wd !== fmt_wd(e))
                begin errors++; $display("FAIL rand_drain: got %b %h/%b/%h expected 1 %h/%b/%h", ok, a, be, wd, {e.addr[31:2], 2'b00}, fmt_be(e), fmt_wd(e)); end
        end
        checks++; if (q.size() != 0 || fifo_count !== 3'd0) begin errors++; $display("FAIL rand_empty: got %0d expected 0", fifo_count); end
    endtask

    task automatic test_flush_commit();
        bit ok; logic [31:0] a, wd; logic [3:0] be; ent_t e, s2;
        s2 = rand_ent();
        capture(0, 2, s2); capture(2, 5, rand_ent());
        step();
        commit(2); flush = 1'b1;
        step();
        checks++; if (fifo_count !== 3'd1 || commit_err !== m_err)
            begin errors++; $display("FAIL flush_commit: got %0d/%b expected 1/%b", fifo_count, commit_err, m_err); end
        commit(5);
        step();
        checks++; if (fifo_count !== 3'd1 || commit_err !== 1'b1)
            begin errors++; $display("FAIL flush_lost_tag: got %0d/%b expected 1/1", fifo_count, commit_err); end
        serve_write(ok, a, be, wd, e);
        checks++; if (!ok || a !== {s2.addr[31:2], 2'b00} || be !== fmt_be(s2) || wd !== fmt_wd(s2))
            begin errors++; $display("FAIL flush_write: got %b %h/%b/%h expected 1 %h/%b/%h", ok, a, be, wd, {s2.addr[31:2], 2'b00}, fmt_be(s2), fmt_wd(s2)); end
    endtask

    task automatic test_reset_mid_store();
        bit ok;
        capture(0, 6, rand_ent()); capture(1, 1, rand_ent());
        step();
        commit(6); step();
        commit(1); step();
        wait_write(ok);
        checks++; if (!ok) begin errors++; $display("FAIL rst_setup: got no write expected write"); end
        #2 rst = 1'b0;
        #1;
        checks++; if (mem_write_d !== 1'b0 || mem_address_d !== 32'd0 || mem_byte_enable_d !== 4'd0)
            begin errors++; $display("FAIL rst_async_bus: got %b/%h/%b expected 0", mem_write_d, mem_address_d, mem_byte_enable_d); end
        checks++; if (fifo_count !== 3'd0 || commit_err !== 1'b0 || new_store !== 1'b0)
            begin errors++; $display("FAIL rst_async_state: got %0d/%b/%b expected 0/0/0", fifo_count, commit_err, new_store); end
        model_reset();
        @(posedge clk);
        #1 rst = 1'b1;
        repeat (3) step();
        checks++; if (mem_write_d !== 1'b0 || mem_read_d !== 1'b0 || fifo_count !== 3'd0)
            begin errors++; $display("FAIL rst_idle_after: got wr=%b rd=%b cnt=%0d expected 0 0 0", mem_write_d, mem_read_d, fifo_count); end
    endtask

    initial begin
        test_reset();
        test_sw_basic();
        test_sub_word();
        test_load_first();
        test_full();
        test_random();
        test_flush_commit();
        test_reset_mid_store();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
